// File: rtl/half_adder.sv
// half_adder: lane-parallel half adder with optional output register and valid flag.
// Build option HALF_ADDER_PARITY_EN adds a parity output (XOR-reduction of s).
module half_adder #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic             out_valid
`ifdef HALF_ADDER_PARITY_EN
  ,
  output logic             parity
`else
`endif
);
  logic [WIDTH-1:0] s_n, c_n;
  assign s_n = x ^ y;
  assign c_n = x & y;
  if (REGISTERED) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        s         <= '0;
        c         <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          s <= s_n;
          c <= c_n;
        end
      end
    end
`ifdef HALF_ADDER_PARITY_EN
    always_ff @(posedge clk) begin
      if (rst) parity <= 1'b0;
      else if (in_valid) parity <= ^s_n;
    end
`else
`endif
  end else begin : g_comb
    // clk and rst are intentionally unused on the combinational path
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign s         = s_n;
    assign c         = c_n;
    assign out_valid = in_valid;
`ifdef HALF_ADDER_PARITY_EN
    assign parity    = ^s_n;
`else
`endif
  end
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: table-driven and randomized checks of half_adder in registered and combinational builds.
module tb_half_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, v;
  logic [0:0] x1, y1, s1, c1, x0, y0, s0, c0;
  logic [3:0] x4, y4, s4, c4;
  logic [2:0] x3, y3, s3, c3;
  logic [7:0] x8, y8, s8, c8;
  logic ov1, ov0, ov4, ov3, ov8;
`ifdef HALF_ADDER_PARITY_EN
  logic p1, p0, p4, p3, p8;
`else
`endif
  int compared = 0, mismatched = 0;

  half_adder #(.WIDTH(1), .REGISTERED(1)) u1 (.clk(clk), .rst(rst), .in_valid(v), .x(x1), .y(y1),
    .s(s1), .c(c1), .out_valid(ov1)
`ifdef HALF_ADDER_PARITY_EN
    , .parity(p1)
`else
`endif
  );
  half_adder #(.WIDTH(1), .REGISTERED(0)) u0 (.clk(clk), .rst(rst), .in_valid(v), .x(x0), .y(y0),
    .s(s0), .c(c0), .out_valid(ov0)
`ifdef HALF_ADDER_PARITY_EN
    , .parity(p0)
`else
`endif
  );
  half_adder #(.WIDTH(4), .REGISTERED(1)) u4 (.clk(clk), .rst(rst), .in_valid(v), .x(x4), .y(y4),
    .s(s4), .c(c4), .out_valid(ov4)
`ifdef HALF_ADDER_PARITY_EN
    , .parity(p4)
`else
`endif
  );
  half_adder #(.WIDTH(3), .REGISTERED(1)) u3 (.clk(clk), .rst(rst), .in_valid(v), .x(x3), .y(y3),
    .s(s3), .c(c3), .out_valid(ov3)
`ifdef HALF_ADDER_PARITY_EN
    , .parity(p3)
`else
`endif
  );
  half_adder #(.WIDTH(8), .REGISTERED(1)) u8 (.clk(clk), .rst(rst), .in_valid(v), .x(x8), .y(y8),
    .s(s8), .c(c8), .out_valid(ov8)
`ifdef HALF_ADDER_PARITY_EN
    , .parity(p8)
`else
`endif
  );

  typedef struct {
    logic x, y, es, ec;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] es8, ec8;
  logic ev8, ep8;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; v = 1'b0;
    x1 = 0; y1 = 0; x0 = 0; y0 = 0; x4 = 0; y4 = 0; x3 = 0; y3 = 0; x8 = 0; y8 = 0;
    #1;
    step();
    step();
    chk("reset_s", s1, 0);
    chk("reset_c", c1, 0);
    chk("reset_ov", ov1, 0);
    chk("reset_s8", s8, 0);
    chk("reset_ov8", ov8, 0);
`ifdef HALF_ADDER_PARITY_EN
    chk("reset_par8", p8, 0);
`else
`endif
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x1 = tbl[i].x; y1 = tbl[i].y; v = 1'b1;
      #1;
      if (i == 0) chk("latency_ov_before_edge", ov1, 0);
      step();
      chk($sformatf("tbl%0d_s", i), s1, tbl[i].es);
      chk($sformatf("tbl%0d_c", i), c1, tbl[i].ec);
      chk($sformatf("tbl%0d_ov", i), ov1, 1);
    end
    x1 = 1; y1 = 1; v = 1;
    step();
    chk("hold_load_ov", ov1, 1);
    for (int i = 0; i < 3; i++) begin
      v = 0; x1 = i[0]; y1 = ~i[0];
      step();
      chk($sformatf("hold%0d_s", i), s1, 0);
      chk($sformatf("hold%0d_c", i), c1, 1);
      chk($sformatf("hold%0d_ov", i), ov1, 0);
    end
    rst = 1; v = 1; x1 = 1; y1 = 0;
    step();
    chk("rstpri_s", s1, 0);
    chk("rstpri_c", c1, 0);
    chk("rstpri_ov", ov1, 0);
    rst = 0; v = 0;
    step();
    chk("postrst_idle_s", s1, 0);
    chk("postrst_idle_ov", ov1, 0);
    v = 1; x1 = 1; y1 = 0;
    step();
    chk("postrst_s", s1, 1);
    chk("postrst_ov", ov1, 1);
    x4 = 4'b1100; y4 = 4'b1010; x3 = 3'b101; y3 = 3'b001; v = 1;
    step();
    chk("w4_s", s4, 4'b0110);
    chk("w4_c", c4, 4'b1000);
    chk("w3_s", s3, 3'b100);
    chk("w3_c", c3, 3'b001);
`ifdef HALF_ADDER_PARITY_EN
    chk("w4_par", p4, 0);
    chk("w3_par", p3, 1);
`else
`endif
    v = 0;
    for (int i = 0; i < 4; i++) begin
      x0 = tbl[i].x; y0 = tbl[i].y;
      #1;
      chk($sformatf("comb%0d_s", i), s0, tbl[i].es);
      chk($sformatf("comb%0d_c", i), c0, tbl[i].ec);
      chk($sformatf("comb%0d_ov", i), ov0, 0);
`ifdef HALF_ADDER_PARITY_EN
      chk($sformatf("comb%0d_par", i), p0, tbl[i].es);
`else
`endif
    end
    v = 1;
    #1;
    chk("comb_ov_follows", ov0, 1);
    rst = 1; v = 0;
    step();
    es8 = 0; ec8 = 0; ev8 = 0; ep8 = 0;
    rst = 0;
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 19) == 0);
      v = $urandom_range(0, 3) != 0;
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      if (rst) begin
        es8 = 0; ec8 = 0; ev8 = 0; ep8 = 0;
      end else begin
        ev8 = v;
        if (v) begin
          int ones;
          ones = 0;
          for (int i = 0; i < 8; i++) begin
            int sum;
            sum = int'(x8[i]) + int'(y8[i]);
            es8[i] = (sum % 2) != 0;
            ec8[i] = (sum / 2) != 0;
            ones += sum % 2;
          end
          ep8 = (ones % 2) != 0;
        end
      end
      step();
      chk($sformatf("rnd%0d_s", n), s8, es8);
      chk($sformatf("rnd%0d_c", n), c8, ec8);
      chk($sformatf("rnd%0d_ov", n), ov8, ev8);
`ifdef HALF_ADDER_PARITY_EN
      chk($sformatf("rnd%0d_par", n), p8, ep8);
`else
`endif
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
